// File: rtl/sgd_dma_pkg.sv
// Shared types and constants for the SGD DMA write-path arbiters.
package sgd_dma_pkg;

  localparam int unsigned DMA_ADDR_W = 64;
  localparam int unsigned DMA_LEN_W  = 32;
  localparam int unsigned BEAT_BYTES = 64;
  localparam int unsigned BEAT_SHIFT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_LEN_W-1:0]  length;
  } dma_cmd_t;

endpackage

// File: rtl/sgd_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping.
module sgd_rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          found_c
);

  logic [IW:0] cand;

  // Scan candidates ptr, ptr+1, ... modulo N; keep the first hit.
  always_comb begin
    gnt_c   = '0;
    idx_c   = '0;
    found_c = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (IW+1)'(ptr) + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found_c && req[IW'(cand)]) begin
        found_c           = 1'b1;
        idx_c             = IW'(cand);
        gnt_c[IW'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sgd_dma_wr_arbiter.sv
// Round-robin arbiter sharing the DMA write channel between NUM_REQ writers.
// Optional per-requester beat and stall counters under SGD_DMA_ARB_PERF_EN.
module sgd_dma_wr_arbiter #(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 512,
  parameter  int unsigned ADDR_WIDTH = sgd_dma_pkg::DMA_ADDR_W,
  parameter  int unsigned LEN_WIDTH  = sgd_dma_pkg::DMA_LEN_W,
  parameter  int unsigned BEAT_BYTES = DATA_WIDTH / 8,
  localparam int unsigned IW         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_length,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_data_valid,
  output logic [NUM_REQ-1:0]            req_data_ready,
  output logic                          dma_wr_start,
  output logic [ADDR_WIDTH-1:0]         dma_wr_addr,
  output logic [LEN_WIDTH-1:0]          dma_wr_length,
  output logic [DATA_WIDTH-1:0]         dma_wr_data,
  output logic                          dma_wr_data_valid,
  input  logic                          dma_wr_almost_full,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  output logic [1:0]                    err_flags
`ifdef SGD_DMA_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]         perf_cnt,
  output logic [31:0]                   stall_cnt
`endif
);

  import sgd_dma_pkg::*;

  localparam int unsigned BL_W = LEN_WIDTH - BEAT_SHIFT + 1;

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  dma_cmd_t              cmd_q, cmd_d;
  logic [BL_W-1:0]       beats_left_q, beats_left_d;
  logic [NUM_REQ-1:0]    req_ready_d;
  logic                  start_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  data_valid_d;
  logic [IW-1:0]         grant_d;
  logic                  busy_d;
  logic [1:0]            err_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IW-1:0]         pick_idx;
  logic                  pick_found;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [LEN_WIDTH-1:0]  len_sel;
  logic [LEN_WIDTH:0]    len_round;
  logic                  xfer_c;

  sgd_rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_c   (pick_gnt),
    .idx_c   (pick_idx),
    .found_c (pick_found)
  );

  // Command fields of the candidate grantee, and its rounded-up beat count.
  assign addr_sel  = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign len_sel   = req_length[pick_idx*LEN_WIDTH +: LEN_WIDTH];
  assign len_round = {1'b0, len_sel} + (LEN_WIDTH+1)'(BEAT_BYTES - 1);

  // A beat moves when the grantee has data and downstream is not almost full.
  assign xfer_c = (state_q == DATA) && !dma_wr_almost_full && req_data_valid[grant_id];

  assign dma_wr_addr   = ADDR_WIDTH'(cmd_q.addr);
  assign dma_wr_length = LEN_WIDTH'(cmd_q.length);

  // Next-state and next-output logic; data ready is combinational on almost_full.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    cmd_d          = cmd_q;
    beats_left_d   = beats_left_q;
    req_ready_d    = '0;
    start_d        = 1'b0;
    data_d         = dma_wr_data;
    data_valid_d   = 1'b0;
    grant_d        = grant_id;
    err_d          = err_flags;
    req_data_ready = '0;

    unique case (state_q)
      IDLE: begin
        // A ready pulse still showing means that command was only just taken.
        if (pick_found && (req_ready == '0)) begin
          req_ready_d  = pick_gnt;
          cmd_d.addr   = DMA_ADDR_W'(addr_sel);
          cmd_d.length = DMA_LEN_W'(len_sel);
          beats_left_d = BL_W'(len_round >> BEAT_SHIFT);
          ptr_d        = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          grant_d      = pick_idx;
          if (len_sel == '0) begin
            err_d[0] = 1'b1;
          end else begin
            state_d = CMD;
            start_d = 1'b1;
          end
        end
      end
      CMD: begin
        state_d = DATA;
        if (cmd_q.addr[BEAT_SHIFT-1:0] != '0) err_d[1] = 1'b1;
      end
      DATA: begin
        req_data_ready[grant_id] = ~dma_wr_almost_full;
        if (xfer_c) begin
          data_d       = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
          data_valid_d = 1'b1;
          beats_left_d = beats_left_q - 1'b1;
          if (beats_left_q == BL_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      ptr_q             <= '0;
      cmd_q             <= '0;
      beats_left_q      <= '0;
      req_ready         <= '0;
      dma_wr_start      <= 1'b0;
      dma_wr_data       <= '0;
      dma_wr_data_valid <= 1'b0;
      grant_id          <= '0;
      busy              <= 1'b0;
      err_flags         <= '0;
    end else begin
      state_q           <= state_d;
      ptr_q             <= ptr_d;
      cmd_q             <= cmd_d;
      beats_left_q      <= beats_left_d;
      req_ready         <= req_ready_d;
      dma_wr_start      <= start_d;
      dma_wr_data       <= data_d;
      dma_wr_data_valid <= data_valid_d;
      grant_id          <= grant_d;
      busy              <= busy_d;
      err_flags         <= err_d;
    end
  end

`ifdef SGD_DMA_ARB_PERF_EN
  // Per-requester beat counters and almost_full stall counter, wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (xfer_c) perf_cnt[grant_id*32 +: 32] <= perf_cnt[grant_id*32 +: 32] + 32'd1;
      if ((state_q == DATA) && dma_wr_almost_full) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sgd_dma_wr_arbiter.sv
// Directed bench for sgd_dma_wr_arbiter (NUM_REQ=4, 512-bit beats).
module tb_sgd_dma_wr_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_valid;
  wire  [3:0]    req_ready;
  logic [255:0]  req_addr;
  logic [127:0]  req_length;
  logic [2047:0] req_data;
  logic [3:0]    req_data_valid;
  wire  [3:0]    req_data_ready;
  wire           dma_wr_start;
  wire  [63:0]   dma_wr_addr;
  wire  [31:0]   dma_wr_length;
  wire  [511:0]  dma_wr_data;
  wire           dma_wr_data_valid;
  logic          dma_wr_almost_full;
  wire  [1:0]    grant_id;
  wire           busy;
  wire  [1:0]    err_flags;
`ifdef SGD_DMA_ARB_PERF_EN
  wire  [127:0]  perf_cnt;
  wire  [31:0]   stall_cnt;
`endif

  sgd_dma_wr_arbiter dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_addr           (req_addr),
    .req_length         (req_length),
    .req_data           (req_data),
    .req_data_valid     (req_data_valid),
    .req_data_ready     (req_data_ready),
    .dma_wr_start       (dma_wr_start),
    .dma_wr_addr        (dma_wr_addr),
    .dma_wr_length      (dma_wr_length),
    .dma_wr_data        (dma_wr_data),
    .dma_wr_data_valid  (dma_wr_data_valid),
    .dma_wr_almost_full (dma_wr_almost_full),
    .grant_id           (grant_id),
    .busy               (busy),
    .err_flags          (err_flags)
`ifdef SGD_DMA_ARB_PERF_EN
    ,
    .perf_cnt           (perf_cnt),
    .stall_cnt          (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [63:0] addr;
    logic [31:0] len;
    int          beats;
    logic        start;
    logic [1:0]  err;
  } vec_t;

  // Requester model: per-requester command list, beats owed and beats handed over.
  logic [63:0] c_addr [4][8];
  logic [31:0] c_len  [4][8];
  int          c_head [4];
  int          c_tail [4];
  int          owed   [4];
  int          taken  [4];
  logic        acc    [4];
  logic        rst_plan;
  logic        af_plan;

  int          lg_ready [$];
  logic [63:0] lg_saddr [$];
  logic [31:0] lg_slen  [$];
  int          lg_sgid  [$];
  logic [31:0] lg_beat  [$];

  int exp_n;
  int exp_r [8];
  int exp_b [8];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] beat_word(input int r, input int s);
    return {8'(r), 24'(s)};
  endfunction

  function automatic int nbeats(input logic [31:0] len);
    return int'((len + 32'd63) / 32'd64);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic scen_clear();
    for (int i = 0; i < 4; i++) begin
      c_head[i] = 0;
      c_tail[i] = 0;
      owed[i]   = 0;
      taken[i]  = 0;
      acc[i]    = 1'b0;
    end
    lg_ready.delete();
    lg_saddr.delete();
    lg_slen.delete();
    lg_sgid.delete();
    lg_beat.delete();
  endtask

  task automatic post(input int r, input logic [63:0] a, input logic [31:0] l);
    c_addr[r][c_tail[r]] = a;
    c_len[r][c_tail[r]]  = l;
    c_tail[r]++;
  endtask

  // One clock: drive after the rising edge, sample on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    rst_n              = rst_plan;
    dma_wr_almost_full = af_plan;
    for (int i = 0; i < 4; i++) begin
      if (acc[i] && (c_head[i] < c_tail[i])) begin
        owed[i] += nbeats(c_len[i][c_head[i]]);
        c_head[i]++;
      end
      acc[i] = 1'b0;
      if (c_head[i] < c_tail[i]) begin
        req_valid[i]             = 1'b1;
        req_addr[i*64 +: 64]     = c_addr[i][c_head[i]];
        req_length[i*32 +: 32]   = c_len[i][c_head[i]];
      end else begin
        req_valid[i] = 1'b0;
      end
      req_data_valid[i]        = (taken[i] < owed[i]);
      req_data[i*512 +: 512]   = 512'(beat_word(i, taken[i]));
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i]) begin
        lg_ready.push_back(i);
        acc[i] = 1'b1;
      end
      if (req_data_valid[i] && req_data_ready[i]) taken[i]++;
    end
    if (dma_wr_start) begin
      lg_saddr.push_back(dma_wr_addr);
      lg_slen.push_back(dma_wr_length);
      lg_sgid.push_back(int'(grant_id));
    end
    if (dma_wr_data_valid) lg_beat.push_back(dma_wr_data[31:0]);
  endtask

  task automatic run_idle(input string nm);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 400) begin
      step();
      n++;
      if (!busy && !dma_wr_data_valid && req_valid == 4'd0 && req_data_valid == 4'd0 &&
          !acc[0] && !acc[1] && !acc[2] && !acc[3]) quiet++;
      else quiet = 0;
    end
    chk({nm, " completes"}, 64'(quiet >= 3), 64'd1);
  endtask

  // Compare logged grants, start count and beat stream against exp_n/exp_r/exp_b.
  task automatic chk_stream(input string nm);
    int seq [4];
    int nstart = 0;
    int k = 0;
    logic [31:0] w;
    for (int i = 0; i < 4; i++) seq[i] = 0;
    chk({nm, " ready_cnt"}, 64'(lg_ready.size()), 64'(exp_n));
    for (int g = 0; g < exp_n; g++) begin
      chk($sformatf("%s grant%0d", nm, g),
          (g < lg_ready.size()) ? 64'(lg_ready[g]) : 64'hFFFF, 64'(exp_r[g]));
      if (exp_b[g] > 0) nstart++;
    end
    chk({nm, " start_cnt"}, 64'(lg_saddr.size()), 64'(nstart));
    for (int g = 0; g < exp_n; g++) k += exp_b[g];
    chk({nm, " beat_cnt"}, 64'(lg_beat.size()), 64'(k));
    k = 0;
    for (int g = 0; g < exp_n; g++) begin
      for (int b = 0; b < exp_b[g]; b++) begin
        w = beat_word(exp_r[g], seq[exp_r[g]]);
        seq[exp_r[g]]++;
        chk($sformatf("%s beat%0d", nm, k),
            (k < lg_beat.size()) ? 64'(lg_beat[k]) : 64'hDEAD_BEEF_0000, 64'(w));
        k++;
      end
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " req_ready"},      64'(req_ready), 64'd0);
    chk({nm, " req_data_ready"}, 64'(req_data_ready), 64'd0);
    chk({nm, " start"},          64'(dma_wr_start), 64'd0);
    chk({nm, " addr"},           dma_wr_addr, 64'd0);
    chk({nm, " length"},         64'(dma_wr_length), 64'd0);
    chk({nm, " data_any"},       64'(|dma_wr_data), 64'd0);
    chk({nm, " data_valid"},     64'(dma_wr_data_valid), 64'd0);
    chk({nm, " grant_id"},       64'(grant_id), 64'd0);
    chk({nm, " busy"},           64'(busy), 64'd0);
    chk({nm, " err_flags"},      64'(err_flags), 64'd0);
  endtask

  vec_t vecs [6];

  initial begin
    int n;
    int bad_rdy;
    int bad_beat;

    vecs[0] = '{r: 0, addr: 64'h1000, len: 32'd256, beats: 4, start: 1'b1, err: 2'b00};
    vecs[1] = '{r: 1, addr: 64'h2000, len: 32'd100, beats: 2, start: 1'b1, err: 2'b00};
    vecs[2] = '{r: 3, addr: 64'h3000, len: 32'd64,  beats: 1, start: 1'b1, err: 2'b00};
    vecs[3] = '{r: 2, addr: 64'h4000, len: 32'd65,  beats: 2, start: 1'b1, err: 2'b00};
    vecs[4] = '{r: 1, addr: 64'h5000, len: 32'd0,   beats: 0, start: 1'b0, err: 2'b01};
    vecs[5] = '{r: 0, addr: 64'h1004, len: 32'd64,  beats: 1, start: 1'b1, err: 2'b11};

    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_length = '0; req_data = '0;
    req_data_valid = '0; dma_wr_almost_full = 1'b0;
    rst_plan = 1'b0; af_plan = 1'b0;
    scen_clear();
    repeat (3) step();
    rst_plan = 1'b1;
    step();
    chk_zero("reset");

    // req0 and req2 together from ptr 0: 0 then 2.
    scen_clear();
    post(0, 64'h100, 32'd64);
    post(2, 64'h200, 32'd64);
    run_idle("rr2");
    exp_n = 2; exp_r[0] = 0; exp_r[1] = 2; exp_b[0] = 1; exp_b[1] = 1;
    chk_stream("rr2");

    // Single req3 command brings ptr back to 0.
    scen_clear();
    post(3, 64'h300, 32'd64);
    run_idle("align");

    // All valid, req0 resubmits: 0,1,2,3,0.
    scen_clear();
    post(0, 64'h400, 32'd64);
    post(0, 64'h440, 32'd64);
    post(1, 64'h500, 32'd64);
    post(2, 64'h600, 32'd64);
    post(3, 64'h700, 32'd64);
    run_idle("rr_all");
    exp_n = 5;
    exp_r[0] = 0; exp_r[1] = 1; exp_r[2] = 2; exp_r[3] = 3; exp_r[4] = 0;
    for (int g = 0; g < 5; g++) exp_b[g] = 1;
    chk_stream("rr_all");

    // Single-command vectors; err_flags column is cumulative.
    for (int v = 0; v < 6; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      scen_clear();
      post(vecs[v].r, vecs[v].addr, vecs[v].len);
      run_idle(nm);
      exp_n = 1; exp_r[0] = vecs[v].r; exp_b[0] = vecs[v].beats;
      chk_stream(nm);
      if (vecs[v].start) begin
        chk({nm, " start_addr"}, (lg_saddr.size() > 0) ? lg_saddr[0] : 64'hX, vecs[v].addr);
        chk({nm, " start_len"},  (lg_slen.size() > 0) ? 64'(lg_slen[0]) : 64'hX, 64'(vecs[v].len));
        chk({nm, " start_gid"},  (lg_sgid.size() > 0) ? 64'(lg_sgid[0]) : 64'hX, 64'(vecs[v].r));
      end
      chk({nm, " grant_id"},  64'(grant_id), 64'(vecs[v].r));
      chk({nm, " err_flags"}, 64'(err_flags), 64'(vecs[v].err));
    end

    // 8-beat transfer, almost_full held for 10 cycles from beat 3.
    scen_clear();
    post(1, 64'h8000, 32'd512);
    n = 0;
    while (taken[1] < 2 && n < 50) begin
      step();
      n++;
    end
    chk("stall reach_beat2", 64'(taken[1] >= 2), 64'd1);
    af_plan  = 1'b1;
    bad_rdy  = 0;
    bad_beat = 0;
    for (int s = 0; s < 10; s++) begin
      step();
      if (req_data_ready != 4'd0) bad_rdy++;
      if (s > 0 && dma_wr_data_valid) bad_beat++;
    end
    chk("stall busy", 64'(busy), 64'd1);
    chk("stall ready_seen", 64'(bad_rdy), 64'd0);
    chk("stall beats_seen", 64'(bad_beat), 64'd0);
    af_plan = 1'b0;
    run_idle("stall");
    exp_n = 1; exp_r[0] = 1; exp_b[0] = 8;
    chk_stream("stall");

    // Reset during beat 2 of 4, then req3 and req0 together must start from ptr 0.
    scen_clear();
    post(0, 64'h9000, 32'd256);
    n = 0;
    while (lg_beat.size() < 1 && n < 50) begin
      step();
      n++;
    end
    chk("midrst reach_beat1", 64'(lg_beat.size()), 64'd1);
    rst_plan = 1'b0;
    step();
    rst_plan = 1'b1;
    scen_clear();
    step();
    chk_zero("midrst");
    scen_clear();
    post(3, 64'hA000, 32'd128);
    post(0, 64'hB000, 32'd128);
    run_idle("postrst");
    exp_n = 2; exp_r[0] = 0; exp_r[1] = 3; exp_b[0] = 2; exp_b[1] = 2;
    chk_stream("postrst");
    chk("postrst len0", (lg_slen.size() > 0) ? 64'(lg_slen[0]) : 64'hX, 64'd128);
    chk("postrst err_flags", 64'(err_flags), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sgd_dma_wr_arbiter.md
Name: sgd_dma_wr_arbiter

Overview:
Shares the single host-memory DMA write channel between NUM_REQ writers, e.g. x-model writeback, loss writeback and status dump. Each writer posts a command (addr, byte length), then streams 512-bit beats. The arbiter grants one writer at a time in round-robin order, forwards its command as a one-cycle start pulse, and passes exactly ceil(length/64) data beats under downstream almost_full back-pressure. It sits in the dma_clk domain, between the per-writer read-data units and the DMA engine.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 512, beat width in bits
ADDR_WIDTH, 64, host byte-address width
LEN_WIDTH, 32, command byte-length width
BEAT_BYTES, 64, bytes per beat (DATA_WIDTH/8)

Ports:
clk  in  1  DMA clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  command pending per requester
req_ready  out  NUM_REQ  one-cycle command accept, one-hot
req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester host byte address
req_length  in  NUM_REQ*LEN_WIDTH  per-requester byte length
req_data  in  NUM_REQ*DATA_WIDTH  per-requester beat data
req_data_valid  in  NUM_REQ  beat available
req_data_ready  out  NUM_REQ  beat taken this cycle
dma_wr_start  out  1  command pulse
dma_wr_addr  out  ADDR_WIDTH  command address
dma_wr_length  out  LEN_WIDTH  command byte length
dma_wr_data  out  DATA_WIDTH  data beat
dma_wr_data_valid  out  1  beat strobe
dma_wr_almost_full  in  1  downstream prog_full
grant_id  out  $clog2(NUM_REQ)  current/last grantee
busy  out  1  state != IDLE
err_flags  out  2  sticky: [0] zero length, [1] addr not 64B-aligned

Behaviour:
- Reset: every output is 0, the round-robin pointer is 0, the beat counter is 0, and the FSM is in IDLE. A reset mid-transfer abandons the transfer with no further beats or pulses. Recovering the partial transfer is the system's responsibility.
- FSM states: IDLE, CMD, DATA.
- IDLE: if any req_valid is set, pick the first set bit at or after ptr, wrapping around. Then:
  - Pulse req_ready[g] for 1 cycle.
  - Latch addr and length.
  - Set beats_left = (length + 63) >> 6, computed in LEN_WIDTH-6+1 bits.
  - Set ptr = g+1 mod NUM_REQ, and set grant_id = g.
  - If length == 0: set err_flags[0] and stay in IDLE. No start pulse is issued, but ptr still advances.
  - Otherwise go to CMD.
- CMD: drive dma_wr_start=1 for one cycle with the latched addr/length, then go to DATA. If addr[5:0] != 0, set err_flags[1]; the command is still forwarded.
- DATA:
  - req_data_ready[g] = ~dma_wr_almost_full; all other requesters' ready = 0.
  - A beat transfers on valid & ready. dma_wr_data / dma_wr_data_valid are registered, giving 1-cycle latency.
  - Each transfer decrements beats_left. On the transfer with beats_left == 1, go to IDLE.
  - The next grant can be accepted in the cycle after returning to IDLE, so there is a minimum 2-cycle gap between commands.
- almost_full is used combinationally. The downstream FIFO's prog_full must therefore leave at least 2 entries of slack.
- Fairness: a requester that holds req_valid continuously is granted within NUM_REQ commands.
- Simultaneous req_valid assertions: only the grantee sees req_ready. The others hold their command stable until accepted.
- req_data_valid asserted by a non-granted requester is ignored.
- err_flags clear only on reset.

Optional Feature:
SGD_DMA_ARB_PERF_EN.
- Defined: adds output perf_cnt (NUM_REQ*32), holding per-requester counters of beats transferred, and output stall_cnt (32), counting DATA cycles with almost_full=1. All counters are reset to 0, wrap modulo 2^32, and are read-only.
- Undefined: these ports and counters are absent and the logic is otherwise identical.

Decomposition:
- Shared package sgd_dma_pkg:
  - state enum (IDLE/CMD/DATA)
  - BEAT_BYTES and the derived BEAT_SHIFT=6
  - typedef dma_cmd_t {addr, length}
- Sub-module sgd_rr_pick: a combinational round-robin first-set finder taking req vector and ptr, returning one-hot grant plus index. It is reused by other arbiters in the design.

Test Plan:
- Single request, req0 addr=0x1000 length=256, data always valid, no almost_full -> 1 req_ready[0] pulse; dma_wr_start with 0x1000/256; exactly 4 valid beats in order; busy drops after the last beat.
- req0 and req2 valid together, length 64 each, ptr=0 -> req0 is granted first, then req2. Next, all requesters are valid: the grant order is 0,1,2,3,0.
- length=100 -> 2 beats forwarded, dma_wr_length=100. length=0 -> err_flags[0]=1, no start pulse, ptr advances.
- DATA with almost_full held high for 10 cycles at beat 3 of 8 -> no req_data_ready and no beats during the stall; the total is still 8 beats, with data order preserved.
- addr=0x1004, length=64 -> err_flags[1]=1, the command is still forwarded, and 1 beat is sent.
- rst_n low for 1 cycle during beat 2 of 4 -> all outputs 0 next cycle; a new request afterwards is granted to req0 from ptr=0 with a fresh beat count.
